// File: rtl/serial_add.sv
// ---------------------------------------------------------------------------
// serial_add
//   Multi-cycle adder: s = a + b + cin, computed CHUNK bits per clock,
//   least-significant chunk first, over N = WIDTH/CHUNK compute cycles.
//   Reports the unsigned carry-out and the signed two's-complement overflow,
//   with a start/busy/done handshake.
//
// Parameters
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per cycle (1, 2, 4, 8, 16 or 32; must divide WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   request, sampled only while not busy
//   a, b   in   signed operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while the add is in progress
//   done   out  one-cycle pulse; results valid from this cycle on
//   s      out  registered signed sum
//   cout   out  registered carry out of bit WIDTH-1
//   ovf    out  registered signed overflow
// ---------------------------------------------------------------------------
module serial_add #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] s,
    output logic                    cout,
    output logic                    ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic                      r_c;
    logic [CNT_W-1:0]          r_cnt;
    logic [WIDTH-1:0]          r_res;
    logic                      r_busy;
    logic                      r_done;
    logic signed [WIDTH-1:0]   r_s;
    logic                      r_cout;
    logic                      r_ovf;

    logic [CHUNK:0]            w_sum;
    logic                      w_c_msb;
    logic [WIDTH-1:0]          w_res_next;
    logic                      w_last;

    // Chunk adder: low CHUNK bits of both operand registers plus the carry.
    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_c};

    // Carry into the top bit of this chunk, recovered from the sum bit and
    // its two addend bits. Only meaningful on the last chunk, where that top
    // bit is bit WIDTH-1 of the full word.
    assign w_c_msb = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];

    // New partial sum enters the result register from the top; after N
    // chunks the first chunk has reached bit 0. Written with shifts so the
    // CHUNK == WIDTH case needs no zero-width slice.
    assign w_res_next = (r_res >> CHUNK)
                      | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    assign w_last = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> CHUNK;
                    r_b   <= r_b >> CHUNK;
                    r_c   <= w_sum[CHUNK];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_cout  <= w_sum[CHUNK];
                        r_ovf   <= w_c_msb ^ w_sum[CHUNK];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    // A start seen during the done cycle begins the next add
                    // immediately, with no idle cycle in between.
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Multi-cycle adder for the MIPSDatapath library. Computes s = a + b + cin over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, LSB chunk first.
- It is the addition counterpart of the combinational 32-bit ripple subtractor.
- Used where a shared, area-cheap adder is acceptable: the multi-cycle ALU path and the PC/offset computations in the iterative datapath.
- Produces the sum, the unsigned carry-out and signed two's-complement overflow, with a start/busy/done handshake.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 4: bits added per cycle. Legal values are 1, 2, 4, 8, 16 and 32. Must divide WIDTH.
- Derived: N = WIDTH/CHUNK, the number of compute cycles.

Ports:
- clk  input  1  rising-edge clock, the single clock of the block.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when busy=0.
- a  input  WIDTH  signed operand, captured on the accepted start edge.
- b  input  WIDTH  signed operand, captured on the accepted start edge.
- cin  input  1  carry-in, captured on the accepted start edge.
- busy  output  1  high while the add is in progress.
- done  output  1  one-cycle pulse. Results are valid from this cycle on.
- s  output  WIDTH  signed sum, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB), registered.

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal operand shift registers, carry and chunk counter are cleared.
  - Reset takes priority over start and over any in-flight operation. A reset during RUN aborts the add, and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: capture a, b and cin into the operand shift registers and the carry register, clear the counter, go to RUN.
- RUN:
  - busy=1, done=0.
  - Each edge:
    - Add the low CHUNK bits of both operand registers plus the carry register, giving a (CHUNK+1)-bit result.
    - Shift the CHUNK-bit partial sum into the result shift register from the top.
    - Shift both operands right by CHUNK.
    - Store the new carry.
    - Increment the counter.
  - On the edge that processes chunk N-1:
    - Load s from the completed result.
    - Set cout to the carry out of bit WIDTH-1.
    - Set ovf to the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
    - Go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - If start=1 on this edge, new operands are captured and the state goes to RUN (back-to-back operation). Otherwise go to IDLE.
- Timing and result holding:
  - If start is sampled at edge E0, busy is high for the N cycles after E0 and done is high in cycle N+1.
  - With WIDTH=32 and CHUNK=4 this is 8 busy cycles, done in the 9th.
  - s, cout and ovf change only at the completion edge (or at reset). They hold their values until the next completion.
- start while busy=1 is ignored: no capture, no queueing, the in-flight result is unaffected.
- Changes on a, b or cin after the capture edge have no effect on the in-flight add.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - cout is the unsigned carry.
  - ovf=1 only when a and b have equal sign bits and s's sign differs from them. cin counts as part of the addition.
- CHUNK=WIDTH degenerates to N=1: busy for 1 cycle, done in the next.

Test Plan:
- Reset, then start with a=5, b=3, cin=0 (WIDTH=32, CHUNK=4): busy high 8 cycles, then done pulses 1 cycle with s=8, cout=0, ovf=0. s is held after done.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> s=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000000, cin=1 -> s=0x80000000, cout=0, ovf=1.
- a=0x80000000, b=0x80000000, cin=0 -> s=0x00000000, cout=1, ovf=1. Then a=0xFFFFFFFE, b=0x00000001, cin=1 -> s=0, cout=1, ovf=0.
- Start a=10, b=20; pulse start with a=100, b=200 at busy cycle 3 -> ignored, done shows s=30. Then hold start high through done with a=1, b=2 -> new add begins with no idle cycle, next done shows s=3.
- Start a=0x12345678, b=0x11111111; assert reset at busy cycle 4 -> next cycle busy=0, done=0, s=0, cout=0, ovf=0, and no done pulse follows. Then a fresh add of the same operands gives s=0x23456789.
- CHUNK=1 and CHUNK=32 builds: a=0xDEADBEEF, b=0x21524111, cin=0 -> s=0x00000000, cout=1, ovf=0. Busy lasts 32 cycles (CHUNK=1) and 1 cycle (CHUNK=32) respectively.
